vco_adc_seq: RTL and testbench
==============================

Name: vco_adc_seq

Overview:
Conversion sequencer for the VCO-based ADC chain (vco -> phase readout -> phase sum -> sinc decimator). It takes a start command with an oversample ratio and sample count, and drives the decimator enable and oversample configuration. It discards the decimator's settling outputs, captures a burst of N converted words into a small FWFT FIFO, and presents them to a host reader over a valid/ready handshake. It sits between the host register block and the ADC instance.

Parameters:
DATA_WIDTH, 32, width of converted words from the decimator.
OSR_WIDTH, 10, width of the oversample ratio.
CNT_WIDTH, 8, width of the sample-count register.
FIFO_DEPTH, 4, capture FIFO depth in words; must be a power of two and at least 2.
SETTLE_SAMPLES, 3, number of decimator valid outputs discarded after enable; 0 means no discard.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous reset, active-low (0 = reset).
start_in  input  1  single-cycle pulse that starts a conversion burst.
abort_in  input  1  terminates the burst.
oversample_cfg_in  input  OSR_WIDTH  oversample ratio, latched on start.
num_samples_in  input  CNT_WIDTH  burst length, latched on start; 0 = continuous.
adc_enable_out  output  1  decimator enable.
adc_oversample_out  output  OSR_WIDTH  oversample ratio to the decimator.
adc_data_in  input  DATA_WIDTH  decimator output word.
adc_valid_in  input  1  decimator output-valid pulse.
rd_data_out  output  DATA_WIDTH  FIFO head word.
rd_valid_out  output  1  FIFO not empty.
rd_ready_in  input  1  reader accepts the head word.
busy_out  output  1  high when the state is SETTLE, ACQUIRE or DRAIN.
done_out  output  1  sticky; burst completed normally.
overflow_out  output  1  sticky; a sample was dropped because the FIFO was full.
sample_count_out  output  CNT_WIDTH  samples taken in the current or last burst.

Behaviour:
- Reset (rst=0 at an edge): state IDLE; FIFO empty; all outputs 0, including adc_oversample_out and rd_data_out.
- States: IDLE, SETTLE, ACQUIRE, DRAIN. All outputs are registered.
- IDLE, start_in=1 (and abort_in=0):
  - latch oversample_cfg_in into adc_oversample_out; a value of 0 is clamped to 1.
  - latch num_samples_in.
  - clear sample_count, done and overflow; flush the FIFO.
  - next state SETTLE, or ACQUIRE if SETTLE_SAMPLES=0.
  - adc_enable_out=1 from the cycle after the start edge.
- start_in outside IDLE is ignored.
- SETTLE: count adc_valid_in pulses and drop their data. When the SETTLE_SAMPLES-th pulse is seen, go to ACQUIRE; that pulse's data is not captured.
- ACQUIRE:
  - on each adc_valid_in, push adc_data_in and increment sample_count.
  - if the FIFO is full and there is no pop in the same cycle, drop the word, set overflow_out, and still increment sample_count.
  - a push and a pop in the same cycle on a full FIFO both succeed; no overflow.
  - when sample_count reaches a non-zero latched num_samples, go to DRAIN and set adc_enable_out=0 next cycle.
  - with num_samples=0, stay in ACQUIRE until abort; sample_count wraps modulo 2^CNT_WIDTH.
- DRAIN: ignore adc_valid_in. When the FIFO is empty, go to IDLE and set done_out=1 in the same update. done_out stays high until the next accepted start or reset.
- adc_valid_in is ignored in IDLE and DRAIN.
- abort_in=1 in any non-IDLE state:
  - next state IDLE; adc_enable_out=0; FIFO flushed; rd_valid_out=0 next cycle.
  - done_out is not set; overflow_out and sample_count_out hold.
  - abort has priority over start_in, adc_valid_in and pops in the same cycle.
- FIFO (first-word fall-through):
  - rd_valid_out = not empty; rd_data_out = head word.
  - a pop occurs when rd_valid_out and rd_ready_in are both 1.
  - a word pushed at edge k is visible at rd_data_out after edge k, if the FIFO was empty.
  - rd_ready_in while empty has no effect.
  - pointers wrap modulo FIFO_DEPTH; full/empty are distinguished by an extra pointer bit.
- Reset asserted mid-burst: immediate return to reset values at that edge.

Test Plan:
- Basic burst: reset, start with OSR=64 and N=4, rd_ready_in=1, 7 valid pulses with data 1..7 → pulses 1–3 dropped; reads 4,5,6,7 in order; busy_out falls and done_out=1 after the last read; sample_count_out=4; adc_enable_out low one cycle after the 7th pulse.
- Backpressure overflow: N=6, rd_ready_in=0, 3 settle pulses plus 6 data pulses → FIFO holds the first 4 data words; overflow_out=1; sample_count_out=6; after rd_ready_in=1, exactly 4 words are read, then done_out=1.
- Full push+pop: FIFO full with rd_ready_in=1 and adc_valid_in in the same cycle → no overflow; occupancy stays 4; order preserved.
- Abort: abort during ACQUIRE after 2 samples, with start_in and adc_valid_in also high that cycle → next cycle IDLE; enable 0; rd_valid_out 0; done_out 0; sample_count_out=2.
- Clamp and ignore: start with OSR=0 → adc_oversample_out=1; a second start_in while busy → no change to the latched config or counts.
- Continuous and reset: N=0 with 300 data pulses → sample_count_out wraps to 44; rst=0 mid-burst → all outputs 0 at the next edge.

Source files
------------

// File: rtl/vco_adc_seq.sv
// -----------------------------------------------------------------------------
// vco_adc_seq
// Conversion sequencer for the VCO-based ADC chain. A start command latches an
// oversample ratio and a burst length and enables the sinc decimator. The first
// SETTLE_SAMPLES decimator outputs are discarded. The next words go into a
// small first-word-fall-through FIFO, and a host reader drains that FIFO.
//
// Ports
//   clk, rst            : system clock; synchronous active-low reset
//   start_in            : one-cycle start pulse, accepted only in IDLE
//   abort_in            : ends the burst from any non-IDLE state
//   oversample_cfg_in   : oversample ratio, latched on start (0 is clamped to 1)
//   num_samples_in      : burst length, latched on start (0 = continuous)
//   adc_enable_out      : decimator enable
//   adc_oversample_out  : latched oversample ratio driven to the decimator
//   adc_data_in         : decimator output word
//   adc_valid_in        : decimator output-valid pulse
//   rd_data_out         : FIFO head word
//   rd_valid_out        : FIFO not empty
//   rd_ready_in         : reader accepts the head word
//   busy_out            : the sequencer is in SETTLE, ACQUIRE or DRAIN
//   done_out            : sticky; the last burst completed normally
//   overflow_out        : sticky; a word was dropped because the FIFO was full
//   sample_count_out    : samples taken in the current or last burst
//
// Read handshake: rd_valid_out is high whenever the FIFO holds a word, and
// rd_data_out then shows the oldest word. The word is consumed at a rising edge
// where rd_valid_out and rd_ready_in are both high. rd_valid_out never depends
// combinationally on rd_ready_in. rd_ready_in has no effect while rd_valid_out
// is low.
//
// Every output comes from a flop. The next FIFO pointers and the next head word
// are computed combinationally, so rd_valid_out and rd_data_out can be
// registered together with the pointers.
// -----------------------------------------------------------------------------
module vco_adc_seq #(
   parameter int DATA_WIDTH     = 32,
   parameter int OSR_WIDTH      = 10,
   parameter int CNT_WIDTH      = 8,
   parameter int FIFO_DEPTH     = 4,
   parameter int SETTLE_SAMPLES = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_in,
   input  logic                  abort_in,
   input  logic [OSR_WIDTH-1:0]  oversample_cfg_in,
   input  logic [CNT_WIDTH-1:0]  num_samples_in,
   output logic                  adc_enable_out,
   output logic [OSR_WIDTH-1:0]  adc_oversample_out,
   input  logic [DATA_WIDTH-1:0] adc_data_in,
   input  logic                  adc_valid_in,
   output logic [DATA_WIDTH-1:0] rd_data_out,
   output logic                  rd_valid_out,
   input  logic                  rd_ready_in,
   output logic                  busy_out,
   output logic                  done_out,
   output logic                  overflow_out,
   output logic [CNT_WIDTH-1:0]  sample_count_out
);

   localparam int PW = $clog2(FIFO_DEPTH);
   // The settle counter only ever holds 0 .. SETTLE_SAMPLES-1.
   localparam int SW = (SETTLE_SAMPLES < 2) ? 1 : $clog2(SETTLE_SAMPLES + 1);

   localparam logic [PW:0]          PTR_ONE     = (PW + 1)'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);
   localparam logic [OSR_WIDTH-1:0] OSR_ONE     = OSR_WIDTH'(1);
   localparam logic [SW-1:0]        SETTLE_ONE  = SW'(1);
   localparam logic [SW-1:0]        SETTLE_LAST =
      (SETTLE_SAMPLES == 0) ? '0 : SW'(SETTLE_SAMPLES - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SETTLE  = 2'd1,
      ACQUIRE = 2'd2,
      DRAIN   = 2'd3
   } state_t;

   state_t                state;
   logic [CNT_WIDTH-1:0]  num_q;        // burst length latched at start
   logic [SW-1:0]         settle_cnt;   // settling pulses already discarded
   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   // The extra MSB tells full apart from empty when the low bits are equal.
   logic [PW:0]           wr_ptr;
   logic [PW:0]           rd_ptr;

   logic                  fifo_full;
   logic                  start_ok;
   logic                  abort_ok;
   logic                  flush;
   logic                  pop;
   logic                  push;
   logic                  push_drop;
   logic [CNT_WIDTH-1:0]  count_inc;
   logic                  last_sample;
   logic [PW:0]           wr_ptr_d;
   logic [PW:0]           rd_ptr_d;
   logic [DATA_WIDTH-1:0] head_d;

   always_comb begin
      fifo_full = (wr_ptr[PW] != rd_ptr[PW]) &&
                  (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

      start_ok = (state == IDLE) && start_in && !abort_in;
      abort_ok = (state != IDLE) && abort_in;
      flush    = start_ok || abort_ok;

      // A flush wins over any pop requested in the same cycle.
      pop = rd_valid_out && rd_ready_in && !flush;

      // On a full FIFO, a same-cycle pop frees the slot that the push reuses.
      push      = (state == ACQUIRE) && adc_valid_in && !abort_ok &&
                  (!fifo_full || pop);
      push_drop = (state == ACQUIRE) && adc_valid_in && !abort_ok &&
                  fifo_full && !pop;

      count_inc   = sample_count_out + CNT_ONE;
      last_sample = (num_q != '0) && (count_inc == num_q);

      wr_ptr_d = wr_ptr;
      rd_ptr_d = rd_ptr;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr + PTR_ONE;
         if (pop)  rd_ptr_d = rd_ptr + PTR_ONE;
      end

      // The next head word is the incoming word when it lands in the head slot.
      // This happens when the FIFO is, or is about to become, empty.
      head_d = mem[rd_ptr_d[PW-1:0]];
      if (push && (wr_ptr[PW-1:0] == rd_ptr_d[PW-1:0])) head_d = adc_data_in;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state              <= IDLE;
         num_q              <= '0;
         settle_cnt         <= '0;
         wr_ptr             <= '0;
         rd_ptr             <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
         adc_enable_out     <= 1'b0;
         adc_oversample_out <= '0;
         rd_data_out        <= '0;
         rd_valid_out       <= 1'b0;
         busy_out           <= 1'b0;
         done_out           <= 1'b0;
         overflow_out       <= 1'b0;
         sample_count_out   <= '0;
      end else begin
         wr_ptr       <= wr_ptr_d;
         rd_ptr       <= rd_ptr_d;
         rd_valid_out <= (wr_ptr_d != rd_ptr_d);
         rd_data_out  <= head_d;
         if (push) mem[wr_ptr[PW-1:0]] <= adc_data_in;

         if (abort_ok) begin
            // done_out, overflow_out and sample_count_out keep their values.
            state          <= IDLE;
            adc_enable_out <= 1'b0;
            busy_out       <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (start_ok) begin
                     adc_oversample_out <= (oversample_cfg_in == '0) ?
                                           OSR_ONE : oversample_cfg_in;
                     num_q              <= num_samples_in;
                     sample_count_out   <= '0;
                     done_out           <= 1'b0;
                     overflow_out       <= 1'b0;
                     settle_cnt         <= '0;
                     adc_enable_out     <= 1'b1;
                     busy_out           <= 1'b1;
                     state              <= (SETTLE_SAMPLES == 0) ? ACQUIRE : SETTLE;
                  end
               end
               SETTLE: begin
                  // The data of settling pulses is discarded, including the last one.
                  if (adc_valid_in) begin
                     if (settle_cnt == SETTLE_LAST) state <= ACQUIRE;
                     else                           settle_cnt <= settle_cnt + SETTLE_ONE;
                  end
               end
               ACQUIRE: begin
                  if (adc_valid_in) begin
                     // A dropped word still counts as a sample taken.
                     sample_count_out <= count_inc;
                     if (push_drop) overflow_out <= 1'b1;
                     if (last_sample) begin
                        state          <= DRAIN;
                        adc_enable_out <= 1'b0;
                     end
                  end
               end
               DRAIN: begin
                  if (!rd_valid_out) begin
                     state    <= IDLE;
                     done_out <= 1'b1;
                     busy_out <= 1'b0;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_vco_adc_seq.sv
// -----------------------------------------------------------------------------
// tb_vco_adc_seq
// Self-checking bench for vco_adc_seq. A behavioural model follows the DUT.
// The model keeps the captured words in a queue and the burst progress in plain
// counters and flags. It is stepped once per clock from the inputs applied for
// that edge, and every output is compared against it on the falling edge.
// Directed sequences add fixed expected values: a cycle table for the basic
// burst, an oversample-clamp table, and the multi-cycle corner cases. A long
// randomized run follows them.
// -----------------------------------------------------------------------------
module tb_vco_adc_seq;

   localparam int DW    = 32;
   localparam int OW    = 10;
   localparam int CW    = 8;
   localparam int DEPTH = 4;
   localparam int SETTLE = 3;

   // ---------------- clock / reset / DUT ----------------
   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start_in = 1'b0;
   logic          abort_in = 1'b0;
   logic [OW-1:0] oversample_cfg_in = '0;
   logic [CW-1:0] num_samples_in = '0;
   logic          adc_enable_out;
   logic [OW-1:0] adc_oversample_out;
   logic [DW-1:0] adc_data_in = '0;
   logic          adc_valid_in = 1'b0;
   logic [DW-1:0] rd_data_out;
   logic          rd_valid_out;
   logic          rd_ready_in = 1'b0;
   logic          busy_out;
   logic          done_out;
   logic          overflow_out;
   logic [CW-1:0] sample_count_out;

   initial forever #5 clk = ~clk;

   vco_adc_seq #(
      .DATA_WIDTH(DW), .OSR_WIDTH(OW), .CNT_WIDTH(CW),
      .FIFO_DEPTH(DEPTH), .SETTLE_SAMPLES(SETTLE)
   ) dut (
      .clk(clk), .rst(rst), .start_in(start_in), .abort_in(abort_in),
      .oversample_cfg_in(oversample_cfg_in), .num_samples_in(num_samples_in),
      .adc_enable_out(adc_enable_out), .adc_oversample_out(adc_oversample_out),
      .adc_data_in(adc_data_in), .adc_valid_in(adc_valid_in),
      .rd_data_out(rd_data_out), .rd_valid_out(rd_valid_out),
      .rd_ready_in(rd_ready_in), .busy_out(busy_out), .done_out(done_out),
      .overflow_out(overflow_out), .sample_count_out(sample_count_out)
   );

   // ---------------- scoreboard / reference model ----------------
   int n_cmp = 0;
   int n_bad = 0;

   logic [DW-1:0] exp_q[$];      // words the reader should see, oldest first
   bit            m_busy = 0;
   bit            m_en = 0;
   bit            m_done = 0;
   bit            m_ovf = 0;
   bit            m_drain = 0;   // burst length reached, waiting for the reader
   int            m_osr = 0;
   int            m_cnt = 0;
   int            m_target = 0;
   int            m_settle_left = 0;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock of the reference model, computed from the inputs applied for this edge.
   task automatic model_step();
      int  pre;
      bit  pop;
      if (!rst) begin
         exp_q.delete();
         m_busy = 0; m_en = 0; m_done = 0; m_ovf = 0; m_drain = 0;
         m_osr = 0; m_cnt = 0; m_target = 0; m_settle_left = 0;
         return;
      end
      pop = (exp_q.size() != 0) && rd_ready_in;
      if (m_busy && abort_in) begin
         m_busy = 0; m_en = 0; m_drain = 0;
         exp_q.delete();
      end else if (!m_busy) begin
         if (start_in && !abort_in) begin
            m_osr = (oversample_cfg_in == 0) ? 1 : int'(oversample_cfg_in);
            m_target = int'(num_samples_in);
            m_cnt = 0; m_done = 0; m_ovf = 0; m_drain = 0;
            m_settle_left = SETTLE;
            m_busy = 1; m_en = 1;
            exp_q.delete();
         end else if (pop) begin
            void'(exp_q.pop_front());
         end
      end else if (m_drain) begin
         if (exp_q.size() == 0) begin
            m_busy = 0; m_done = 1; m_drain = 0;
         end else if (pop) begin
            void'(exp_q.pop_front());
         end
      end else if (m_settle_left > 0) begin
         if (pop) void'(exp_q.pop_front());
         if (adc_valid_in) m_settle_left--;
      end else begin
         pre = exp_q.size();
         if (pop) void'(exp_q.pop_front());
         if (adc_valid_in) begin
            if (pre < DEPTH || pop) exp_q.push_back(adc_data_in);
            else                    m_ovf = 1;
            m_cnt = (m_cnt + 1) % (1 << CW);
            if (m_target != 0 && m_cnt == m_target) begin
               m_drain = 1; m_en = 0;
            end
         end
      end
   endtask

   task automatic check_model();
      check("m_rd_valid", DW'(rd_valid_out), DW'(exp_q.size() != 0));
      if (exp_q.size() != 0) check("m_rd_data", rd_data_out, exp_q[0]);
      check("m_enable",    DW'(adc_enable_out),     DW'(m_en));
      check("m_osr",       DW'(adc_oversample_out), DW'(m_osr));
      check("m_busy",      DW'(busy_out),           DW'(m_busy));
      check("m_done",      DW'(done_out),           DW'(m_done));
      check("m_overflow",  DW'(overflow_out),       DW'(m_ovf));
      check("m_count",     DW'(sample_count_out),   DW'(m_cnt % (1 << CW)));
   endtask

   // ---------------- driver tasks ----------------
   task automatic cycle();
      model_step();
      @(posedge clk);
      @(negedge clk);
      check_model();
   endtask

   task automatic do_start(input logic [OW-1:0] osr, input logic [CW-1:0] n);
      oversample_cfg_in = osr;
      num_samples_in    = n;
      start_in          = 1'b1;
      cycle();
      start_in          = 1'b0;
   endtask

   task automatic valid_pulses(input int count, input logic [DW-1:0] base);
      for (int i = 0; i < count; i++) begin
         adc_valid_in = 1'b1;
         adc_data_in  = base + DW'(i);
         cycle();
      end
      adc_valid_in = 1'b0;
   endtask

   task automatic do_abort();
      abort_in = 1'b1;
      cycle();
      abort_in = 1'b0;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_en"},    DW'(adc_enable_out),     '0);
      check({tag, "_osr"},   DW'(adc_oversample_out), '0);
      check({tag, "_rv"},    DW'(rd_valid_out),       '0);
      check({tag, "_rdata"}, rd_data_out,             '0);
      check({tag, "_busy"},  DW'(busy_out),           '0);
      check({tag, "_done"},  DW'(done_out),           '0);
      check({tag, "_ovf"},   DW'(overflow_out),       '0);
      check({tag, "_cnt"},   DW'(sample_count_out),   '0);
   endtask

   // Reads words with rd_ready_in high and checks them against an arithmetic
   // sequence. Stops when the FIFO is empty and the sequencer is idle, or when
   // the cycle budget runs out.
   task automatic read_out(input string tag, input logic [DW-1:0] first, input int budget,
                           output int nread);
      nread = 0;
      rd_ready_in = 1'b1;
      for (int k = 0; k < budget; k++) begin
         if (!rd_valid_out && !busy_out) break;
         if (rd_valid_out) begin
            check({tag, "_word"}, rd_data_out, first + DW'(nread));
            nread++;
         end
         cycle();
      end
   endtask

   // ---------------- vector table for the basic burst ----------------
   typedef struct {
      logic          start;
      logic          valid;
      logic [DW-1:0] data;
      logic          busy;
      logic          en;
      logic          rv;
      logic [DW-1:0] rd;
      logic          done;
      logic [CW-1:0] cnt;
   } vec_t;

   typedef struct {
      logic [OW-1:0] cfg;
      logic [OW-1:0] exp_osr;
   } osr_vec_t;

   vec_t     burst[11];
   osr_vec_t osr_tab[6];

   initial begin
      int nread;
      bit slow;

      //                start valid data  busy en rv rd done cnt
      burst[0]  = '{1'b1, 1'b0, 0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 8'd0};
      burst[1]  = '{1'b0, 1'b1, 1, 1'b1, 1'b1, 1'b0, 0, 1'b0, 8'd0};
      burst[2]  = '{1'b0, 1'b1, 2, 1'b1, 1'b1, 1'b0, 0, 1'b0, 8'd0};
      burst[3]  = '{1'b0, 1'b1, 3, 1'b1, 1'b1, 1'b0, 0, 1'b0, 8'd0};
      burst[4]  = '{1'b0, 1'b1, 4, 1'b1, 1'b1, 1'b1, 4, 1'b0, 8'd1};
      burst[5]  = '{1'b0, 1'b1, 5, 1'b1, 1'b1, 1'b1, 5, 1'b0, 8'd2};
      burst[6]  = '{1'b0, 1'b1, 6, 1'b1, 1'b1, 1'b1, 6, 1'b0, 8'd3};
      burst[7]  = '{1'b0, 1'b1, 7, 1'b1, 1'b0, 1'b1, 7, 1'b0, 8'd4};
      burst[8]  = '{1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 8'd4};
      burst[9]  = '{1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 8'd4};
      burst[10] = '{1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 8'd4};

      osr_tab[0] = '{10'd0,    10'd1};
      osr_tab[1] = '{10'd1,    10'd1};
      osr_tab[2] = '{10'd2,    10'd2};
      osr_tab[3] = '{10'd64,   10'd64};
      osr_tab[4] = '{10'd511,  10'd511};
      osr_tab[5] = '{10'd1023, 10'd1023};

      // ---- reset ----
      rst = 1'b0;
      repeat (3) cycle();
      check_zero("reset");
      rst = 1'b1;
      cycle();

      // ---- basic burst, cycle table ----
      oversample_cfg_in = 10'd64;
      num_samples_in    = 8'd4;
      rd_ready_in       = 1'b1;
      for (int i = 0; i < 11; i++) begin
         start_in     = burst[i].start;
         adc_valid_in = burst[i].valid;
         adc_data_in  = burst[i].data;
         cycle();
         check($sformatf("burst%0d_busy", i), DW'(busy_out),         DW'(burst[i].busy));
         check($sformatf("burst%0d_en", i),   DW'(adc_enable_out),   DW'(burst[i].en));
         check($sformatf("burst%0d_rv", i),   DW'(rd_valid_out),     DW'(burst[i].rv));
         if (burst[i].rv) check($sformatf("burst%0d_rd", i), rd_data_out, burst[i].rd);
         check($sformatf("burst%0d_done", i), DW'(done_out),         DW'(burst[i].done));
         check($sformatf("burst%0d_cnt", i),  DW'(sample_count_out), DW'(burst[i].cnt));
      end
      start_in = 1'b0; adc_valid_in = 1'b0;
      check("burst_osr", DW'(adc_oversample_out), 32'd64);

      // ---- oversample latch / clamp table ----
      for (int i = 0; i < 6; i++) begin
         do_start(osr_tab[i].cfg, 8'd3);
         check($sformatf("osr%0d", i), DW'(adc_oversample_out), DW'(osr_tab[i].exp_osr));
         do_abort();
         check($sformatf("osr%0d_hold", i), DW'(adc_oversample_out), DW'(osr_tab[i].exp_osr));
      end

      // ---- backpressure overflow ----
      rd_ready_in = 1'b0;
      do_start(10'd8, 8'd6);
      valid_pulses(SETTLE, 32'hE0);
      valid_pulses(6, 32'h10);
      check("ovf_flag",  DW'(overflow_out),     32'd1);
      check("ovf_cnt",   DW'(sample_count_out), 32'd6);
      check("ovf_en",    DW'(adc_enable_out),   32'd0);
      check("ovf_head",  rd_data_out,           32'h10);
      read_out("ovf", 32'h10, 12, nread);
      check("ovf_nread", DW'(nread),            32'd4);
      check("ovf_done",  DW'(done_out),         32'd1);
      check("ovf_busy",  DW'(busy_out),         32'd0);

      // ---- push and pop on a full FIFO ----
      rd_ready_in = 1'b0;
      do_start(10'd8, 8'd8);
      valid_pulses(SETTLE, 32'hE0);
      valid_pulses(DEPTH, 32'hA0);
      check("full_rv", DW'(rd_valid_out), 32'd1);
      rd_ready_in  = 1'b1;
      adc_valid_in = 1'b1;
      adc_data_in  = 32'hA4;
      cycle();
      adc_valid_in = 1'b0;
      check("full_ovf",  DW'(overflow_out), 32'd0);
      check("full_head", rd_data_out,       32'hA1);
      read_out("full", 32'hA1, 8, nread);
      check("full_nread", DW'(nread),       32'd4);
      check("full_busy",  DW'(busy_out),    32'd1);
      do_abort();

      // ---- abort with start and valid in the same cycle ----
      rd_ready_in = 1'b0;
      do_start(10'd9, 8'd10);
      valid_pulses(SETTLE, 32'hE0);
      valid_pulses(2, 32'h41);
      abort_in = 1'b1; start_in = 1'b1; adc_valid_in = 1'b1; rd_ready_in = 1'b1;
      adc_data_in = 32'h43; oversample_cfg_in = 10'd300; num_samples_in = 8'd1;
      cycle();
      abort_in = 1'b0; start_in = 1'b0; adc_valid_in = 1'b0;
      check("abort_busy", DW'(busy_out),           32'd0);
      check("abort_en",   DW'(adc_enable_out),     32'd0);
      check("abort_rv",   DW'(rd_valid_out),       32'd0);
      check("abort_done", DW'(done_out),           32'd0);
      check("abort_cnt",  DW'(sample_count_out),   32'd2);
      check("abort_osr",  DW'(adc_oversample_out), 32'd9);

      // ---- clamp, and start ignored while busy ----
      rd_ready_in = 1'b1;
      do_start(10'd0, 8'd5);
      check("clamp_osr", DW'(adc_oversample_out), 32'd1);
      do_start(10'd77, 8'd2);
      check("ignore_osr",  DW'(adc_oversample_out), 32'd1);
      check("ignore_busy", DW'(busy_out),           32'd1);
      valid_pulses(SETTLE, 32'hE0);
      valid_pulses(5, 32'h50);
      for (int k = 0; k < 10 && busy_out; k++) cycle();
      check("ignore_cnt",  DW'(sample_count_out), 32'd5);
      check("ignore_done", DW'(done_out),         32'd1);
      check("ignore_busy2", DW'(busy_out),        32'd0);

      // ---- continuous mode wrap, then reset mid-burst ----
      rd_ready_in = 1'b1;
      do_start(10'd16, 8'd0);
      valid_pulses(SETTLE, 32'hE0);
      valid_pulses(300, 32'h0);
      check("cont_cnt",  DW'(sample_count_out), 32'd44);
      check("cont_busy", DW'(busy_out),         32'd1);
      check("cont_en",   DW'(adc_enable_out),   32'd1);
      check("cont_ovf",  DW'(overflow_out),     32'd0);
      adc_valid_in = 1'b1;
      cycle();
      rst = 1'b0;
      cycle();
      adc_valid_in = 1'b0;
      check_zero("midrst");
      rst = 1'b1;
      cycle();

      // ---- randomized run against the model ----
      slow = 0;
      for (int i = 0; i < 3000; i++) begin
         if (i % 64 == 0) slow = ($urandom_range(0, 1) == 1);
         rst               = ($urandom_range(0, 399) != 0);
         start_in          = ($urandom_range(0, 3) == 0);
         abort_in          = ($urandom_range(0, 63) == 0);
         adc_valid_in      = ($urandom_range(0, 1) == 1);
         adc_data_in       = $urandom;
         rd_ready_in       = slow ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
         oversample_cfg_in = ($urandom_range(0, 3) == 0) ? '0 : OW'($urandom_range(0, 1023));
         num_samples_in    = CW'($urandom_range(0, 12));
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      n_bad++;
      $display("FAIL watchdog: actual=still running required=finished");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "watchdog expired");
   end

endmodule
